// File: rtl/next_pc_unit.sv
// next_pc_unit: program counter sequencer with branch/jump redirect, stall and halt.
// Optional redirect counter enabled by defining NEXT_PC_UNIT_TAKEN_CNT_EN.
module next_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction,
  input  logic        InstrReady,
  input  logic        Zero,
  input  logic        Beq,
  input  logic        Bne,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic [31:0] JrTarget,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Taken,
  output logic        Halted,
  output logic [31:0] TakenCount
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state, state_nx;
  logic br, accept;
  logic [31:0] next_pc;
  assign PCPlus4 = PC + 32'd4;
  assign br = (Beq & Zero) | (Bne & ~Zero);
  assign Taken = (state == RUN) & (Jump | JumpReg | br);
  assign Halted = state == HALT;
  assign accept = (state == RUN) & InstrReady;
  always_comb begin
    next_pc = Jump ? {PCPlus4[31:28], Instruction[25:0], 2'b00} :
              JumpReg ? JrTarget :
              br ? PCPlus4 + {{14{Instruction[15]}}, Instruction[15:0], 2'b00} : PCPlus4;
    state_nx = state == BOOT ? RUN :
               (accept && Instruction[31:26] == 6'h3f) ? HALT : state;
  end
  // the halt instruction keeps PC at its own address
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      PC <= RESET_PC;
    end else begin
      state <= state_nx;
      if (accept && state_nx == RUN) PC <= next_pc & ~32'd3;
    end
  end
`ifdef NEXT_PC_UNIT_TAKEN_CNT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (accept && Taken && cnt != 32'hFFFF_FFFF) cnt <= cnt + 32'd1;
  end
  assign TakenCount = cnt;
`else
  assign TakenCount = '0;
`endif
endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: directed and randomized checks of next_pc_unit against a behavioural model.
module tb_next_pc_unit;
  localparam logic [31:0] RP = 32'h0000_3000;
`ifdef NEXT_PC_UNIT_TAKEN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clk = 0, reset = 1;
  logic [31:0] instr = 0, jrt = 0;
  logic ready = 0, zero = 0, beq = 0, bne = 0, jump = 0, jumpreg = 0;
  logic [31:0] pc, pc4, tcnt;
  logic taken, halted;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_pc = RP, m_cnt = 0;
  bit m_boot = 1, m_halt = 0;

  next_pc_unit #(.RESET_PC(RP)) dut (
    .clk(clk), .reset(reset), .Instruction(instr), .InstrReady(ready), .Zero(zero),
    .Beq(beq), .Bne(bne), .Jump(jump), .JumpReg(jumpreg), .JrTarget(jrt),
    .PC(pc), .PCPlus4(pc4), .Taken(taken), .Halted(halted), .TakenCount(tcnt)
  );

  always #5 clk = ~clk;

  function automatic bit m_br();
    return (beq && zero) || (bne && !zero);
  endfunction

  function automatic bit m_taken();
    return !m_boot && !m_halt && (jump || jumpreg || m_br());
  endfunction

  function automatic logic [31:0] m_target();
    logic [31:0] p4;
    int off;
    p4 = m_pc + 32'd4;
    off = int'($signed(instr[15:0])) * 4;
    if (jump) return {p4[31:28], instr[25:0], 2'b00};
    if (jumpreg) return jrt & 32'hFFFF_FFFC;
    if (m_br()) return p4 + 32'(off);
    return p4;
  endfunction

  task automatic go(input logic [31:0] i, input bit rdy, z, bq, bn, j, jr, input logic [31:0] t);
    @(negedge clk);
    instr = i; ready = rdy; zero = z; beq = bq; bne = bn; jump = j; jumpreg = jr; jrt = t;
  endtask

  task automatic tick();
    bit tk;
    logic [31:0] t;
    tk = m_taken();
    t = m_target();
    @(posedge clk);
    if (reset) begin
      m_pc = RP; m_boot = 1; m_halt = 0; m_cnt = 0;
    end else if (m_boot) m_boot = 0;
    else if (!m_halt && ready) begin
      if (tk && CNT_EN && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (instr[31:26] == 6'h3f) m_halt = 1;
      else m_pc = t;
    end
    #1;
  endtask

  task automatic test_reset();
    go($urandom, 1, 1, 1, 1, 1, 1, $urandom);
    reset = 1;
    tick();
    n_cmp += 5;
    if (pc !== RP) begin n_bad++; $display("FAIL reset_pc got %h want %h", pc, RP); end
    if (pc4 !== RP + 4) begin n_bad++; $display("FAIL reset_pc4 got %h want %h", pc4, RP + 4); end
    if (halted !== 0) begin n_bad++; $display("FAIL reset_halted got %b want 0", halted); end
    if (tcnt !== 0) begin n_bad++; $display("FAIL reset_cnt got %h want 0", tcnt); end
    if (taken !== 0) begin n_bad++; $display("FAIL boot_taken got %b want 0", taken); end
    go(0, 1, 0, 0, 0, 0, 0, 0);
    reset = 0;
    tick();
    n_cmp++;
    if (pc !== RP) begin n_bad++; $display("FAIL boot_hold got %h want %h", pc, RP); end
    tick();
    n_cmp++;
    if (pc !== RP + 4) begin n_bad++; $display("FAIL run_seq1 got %h want %h", pc, RP + 4); end
    tick();
    n_cmp++;
    if (pc !== RP + 8) begin n_bad++; $display("FAIL run_seq2 got %h want %h", pc, RP + 8); end
  endtask

  task automatic test_branch();
    go(0, 1, 0, 0, 0, 0, 1, 32'h100);
    tick();
    go(32'h0000_FFFF, 1, 1, 1, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (taken !== 1) begin n_bad++; $display("FAIL beq_taken got %b want 1", taken); end
    tick();
    n_cmp++;
    if (pc !== 32'h100) begin n_bad++; $display("FAIL beq_back got %h want 00000100", pc); end
    go(32'h0000_FFFF, 1, 0, 1, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (taken !== 0) begin n_bad++; $display("FAIL beq_not_taken got %b want 0", taken); end
    tick();
    n_cmp++;
    if (pc !== 32'h104) begin n_bad++; $display("FAIL beq_fall got %h want 00000104", pc); end
    go(0, 1, 0, 0, 0, 0, 1, 32'h100);
    tick();
    go(32'h0000_0003, 1, 0, 0, 1, 0, 0, 0);
    tick();
    n_cmp++;
    if (pc !== 32'h110) begin n_bad++; $display("FAIL bne_fwd got %h want 00000110", pc); end
    go(32'h0000_0008, 1, 1, 1, 1, 0, 0, 0);
    tick();
    n_cmp++;
    if (pc !== 32'h134) begin n_bad++; $display("FAIL beq_bne_both got %h want 00000134", pc); end
  endtask

  task automatic test_jump_priority();
    logic [31:0] c0;
    go(0, 1, 0, 0, 0, 0, 1, 32'h4000_0010);
    tick();
    c0 = m_cnt;
    go({6'd2, 26'h0000040}, 1, 1, 1, 0, 1, 0, 0);
    tick();
    n_cmp += 2;
    if (pc !== 32'h4000_0100) begin n_bad++; $display("FAIL jump_prio got %h want 40000100", pc); end
    if (tcnt !== c0 + 32'(CNT_EN)) begin n_bad++; $display("FAIL jump_cnt got %h want %h", tcnt, c0 + 32'(CNT_EN)); end
    go(0, 1, 0, 0, 0, 0, 1, 32'h0000_2003);
    tick();
    n_cmp++;
    if (pc !== 32'h2000) begin n_bad++; $display("FAIL jr_align got %h want 00002000", pc); end
  endtask

  task automatic test_stall();
    logic [31:0] c0;
    c0 = m_cnt;
    go({6'd2, 26'h0000100}, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (taken !== 1) begin n_bad++; $display("FAIL stall_taken got %b want 1", taken); end
      tick();
      n_cmp += 2;
      if (pc !== 32'h2000) begin n_bad++; $display("FAIL stall_pc got %h want 00002000", pc); end
      if (tcnt !== c0) begin n_bad++; $display("FAIL stall_cnt got %h want %h", tcnt, c0); end
    end
    go({6'd2, 26'h0000100}, 1, 0, 0, 0, 1, 0, 0);
    tick();
    n_cmp += 2;
    if (pc !== 32'h400) begin n_bad++; $display("FAIL stall_release got %h want 00000400", pc); end
    if (tcnt !== c0 + 32'(CNT_EN)) begin n_bad++; $display("FAIL stall_cnt_inc got %h want %h", tcnt, c0 + 32'(CNT_EN)); end
    go({6'd2, 26'h0000300}, 0, 0, 0, 0, 1, 0, 0);
    reset = 1;
    tick();
    reset = 0;
    n_cmp += 2;
    if (pc !== RP) begin n_bad++; $display("FAIL stall_reset_pc got %h want %h", pc, RP); end
    if (tcnt !== 0) begin n_bad++; $display("FAIL stall_reset_cnt got %h want 0", tcnt); end
    go(0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    n_cmp++;
    if (pc !== RP + 4) begin n_bad++; $display("FAIL post_reset_seq got %h want %h", pc, RP + 4); end
  endtask

  task automatic test_wrap_halt();
    go(0, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    tick();
    go(0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    n_cmp++;
    if (pc !== 32'h0) begin n_bad++; $display("FAIL wrap got %h want 00000000", pc); end
    go(0, 1, 0, 0, 0, 0, 1, 32'h20);
    tick();
    go({6'h3f, 26'h0}, 1, 0, 0, 0, 0, 0, 0);
    tick();
    n_cmp += 2;
    if (halted !== 1) begin n_bad++; $display("FAIL halt_flag got %b want 1", halted); end
    if (pc !== 32'h20) begin n_bad++; $display("FAIL halt_pc got %h want 00000020", pc); end
    go({6'd2, 26'h1234}, 1, 0, 0, 0, 1, 0, 0);
    #1;
    n_cmp++;
    if (taken !== 0) begin n_bad++; $display("FAIL halt_taken got %b want 0", taken); end
    tick();
    tick();
    n_cmp += 2;
    if (pc !== 32'h20) begin n_bad++; $display("FAIL halt_hold got %h want 00000020", pc); end
    if (halted !== 1) begin n_bad++; $display("FAIL halt_stay got %b want 1", halted); end
    reset = 1;
    tick();
    reset = 0;
    n_cmp += 3;
    if (pc !== RP) begin n_bad++; $display("FAIL halt_reset_pc got %h want %h", pc, RP); end
    if (halted !== 0) begin n_bad++; $display("FAIL halt_reset_flag got %b want 0", halted); end
    if (pc4 !== RP + 4) begin n_bad++; $display("FAIL halt_reset_pc4 got %h want %h", pc4, RP + 4); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      go($urandom, ($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
         ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), $urandom);
      reset = ($urandom_range(0, 39) == 0);
      #1;
      n_cmp++;
      if (taken !== (reset ? taken : m_taken()) && !reset) begin n_bad++; $display("FAIL rnd_taken got %b want %b", taken, m_taken()); end
      tick();
      n_cmp += 4;
      if (pc !== m_pc) begin n_bad++; $display("FAIL rnd_pc got %h want %h", pc, m_pc); end
      if (pc4 !== m_pc + 32'd4) begin n_bad++; $display("FAIL rnd_pc4 got %h want %h", pc4, m_pc + 32'd4); end
      if (halted !== m_halt) begin n_bad++; $display("FAIL rnd_halted got %b want %b", halted, m_halt); end
      if (tcnt !== m_cnt) begin n_bad++; $display("FAIL rnd_cnt got %h want %h", tcnt, m_cnt); end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump_priority();
    test_stall();
    test_wrap_halt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
